interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Parameter N_IRQ, default 8: number of interrupt channels, 1..32.
REQ-002 Parameter ID_W, default 3: width of channel id; N_IRQ SHALL be <= 2**ID_W.
REQ-003 Parameter VEC_BASE, default 32'h0000_0100: vector address of channel 0.
REQ-004 Parameter VEC_STRIDE, default 32'h0000_0010: vector spacing between channels.
REQ-005 clk  input  1  main clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 irq_in  input  N_IRQ  raw interrupt lines, synchronous to clk.
REQ-008 cfg_wen  input  1  config register write strobe.
REQ-009 cfg_addr  input  2  register select: 0 MASK, 1 PEND, 2 MODE, 3 STATUS.
REQ-010 cfg_wdata  input  32  write data; bits above N_IRQ-1 ignored.
REQ-011 cfg_rdata  output  32  combinational read of the register selected by cfg_addr, unused bits 0.
REQ-012 ir_req  output  1  interrupt request to the co-processor.
REQ-013 ir_id  output  ID_W  id of the requested or in-service channel.
REQ-014 jump_addr  output  32  VEC_BASE + ir_id*VEC_STRIDE, modulo 2**32.
REQ-015 ir_ack  input  1  co-processor accepts the request.
REQ-016 eret  input  1  return from handler.
REQ-017 busy  output  1  high in SERVICE.

Function
REQ-018 Edge detect: per channel, a registered previous sample; pending bit set after edge k when irq_in=1 at edge k and previous sample=0.
REQ-019 PEND write is write-1-to-clear; a set event and a clear in the same cycle leave the bit set.
REQ-020 MASK write replaces the mask; bit=1 enables the channel.
REQ-021 STATUS reads {busy at bit ID_W, ir_id at bits ID_W-1:0}; writes are ignored.
REQ-022 FSM states: IDLE, REQ, SERVICE.
REQ-023 IDLE: if (PEND & MASK) != 0, the controller SHALL latch the lowest set index into ir_id and go to REQ next edge; ir_req is high only in REQ.
REQ-024 Latency: pending visible after edge k gives ir_req high after edge k+1.
REQ-025 REQ: ir_id and jump_addr are held stable until ir_ack, regardless of later MASK/PEND changes.
REQ-026 REQ with ir_ack=1: go to SERVICE; clear the PEND bit of ir_id unless a new edge on that channel occurs in the same cycle, in which case it stays set.
REQ-027 SERVICE: new edges are latched into PEND but not requested; eret=1 returns to IDLE, and arbitration resumes the following cycle.
REQ-028 eret in IDLE or REQ, and ir_ack outside REQ, are ignored.
REQ-029 ir_id holds its last value in IDLE.

Reset
REQ-030 While rst=1: state IDLE; MASK, PEND, MODE, previous samples and ir_id are 0; ir_req=0, busy=0, jump_addr=VEC_BASE.
REQ-031 Reset asserted in REQ or SERVICE aborts the request or service immediately, with no ack or eret required.

Configuration
REQ-032 Macro IRQ_LEVEL_MODE_EN.
REQ-033 Defined: MODE bit=1 makes that channel level-sensitive. Its PEND bit equals irq_in, and ack or W1C do not clear it. MODE bit=0 channels are edge-sensitive.
REQ-034 Undefined: MODE reads 0, writes are ignored, and all channels are edge-sensitive.

Verification
REQ-035 MASK=8'h04, pulse irq_in[2] for 1 cycle -> ir_req high 2 edges later, ir_id=2, jump_addr=32'h120; ir_ack -> busy=1, PEND=0.
REQ-036 MASK=8'hFF, irq_in[5] and irq_in[1] rise together -> ir_id=1; after ir_ack and eret -> a second request with ir_id=5, jump_addr=32'h150.
REQ-037 In SERVICE, pulse irq_in[0] -> no ir_req until eret; then ir_req with ir_id=0.
REQ-038 MASK=0, pulse irq_in[3] -> PEND=8'h08, no ir_req; write PEND=8'h08 in the same cycle as a new irq_in[3] edge -> PEND stays 8'h08.
REQ-039 In REQ, assert rst -> ir_req=0 with no clock edge; all registers read 0.
REQ-040 With IRQ_LEVEL_MODE_EN, MODE=8'h01, hold irq_in[0]=1 -> request re-issued after each eret until irq_in[0]=0.

Source files
------------

// File: rtl/interrupt_ctrl.sv
// Prioritised interrupt controller: edge-detected pending bits, mask, lowest-index arbitration, req/ack/eret handshake.
// Optional per-channel level sensitivity (MODE register) is built in when IRQ_LEVEL_MODE_EN is defined.
module interrupt_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter int unsigned ID_W       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             cfg_wen,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             ir_req,
    output logic [ID_W-1:0]  ir_id,
    output logic [31:0]      jump_addr,
    input  logic             ir_ack,
    input  logic             eret,
    output logic             busy
);

    localparam int unsigned ADDR_W = 2;
    localparam logic [ADDR_W-1:0] A_MASK   = 2'd0;
    localparam logic [ADDR_W-1:0] A_PEND   = 2'd1;
    localparam logic [ADDR_W-1:0] A_MODE   = 2'd2;
    localparam logic [ADDR_W-1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IRQ-1:0]  prev_q, mask_q, pend_q, mode_q;
    logic [N_IRQ-1:0]  pend_d, mask_d, active_c, edge_c;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       jump_q, jump_d;
    logic              req_q, busy_q;
    logic              unused_wdata;

    assign unused_wdata = ^cfg_wdata;
    assign active_c     = pend_q & mask_q;
    assign edge_c       = irq_in & ~prev_q & ~mode_q;

`ifdef IRQ_LEVEL_MODE_EN
    // MODE register: 1 selects level sensitivity for that channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
        end else if (cfg_wen && cfg_addr == A_MODE) begin
            mode_q <= cfg_wdata[N_IRQ-1:0];
        end
    end
`else
    assign mode_q = '0;
`endif

    // Next state, arbitration and pending-bit update
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        mask_d  = mask_q;
        pend_d  = pend_q;

        case (state_q)
            IDLE: begin
                if (active_c != '0) begin
                    state_d = REQ;
                    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
                        if (active_c[i]) id_d = ID_W'(i);
                    end
                end
            end
            REQ: begin
                if (ir_ack) begin
                    state_d = SERVICE;
                    for (int i = 0; i < int'(N_IRQ); i++) begin
                        if (ID_W'(i) == id_q) pend_d[i] = 1'b0;
                    end
                end
            end
            SERVICE: begin
                if (eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cfg_wen && cfg_addr == A_MASK) mask_d = cfg_wdata[N_IRQ-1:0];
        if (cfg_wen && cfg_addr == A_PEND) pend_d = pend_d & ~cfg_wdata[N_IRQ-1:0];
        // New edges win over ack-clear and W1C in the same cycle
        pend_d = pend_d | edge_c;
        // Level channels simply track the line
        pend_d = (pend_d & ~mode_q) | (irq_in & mode_q);

        jump_d = VEC_BASE + 32'(id_d) * VEC_STRIDE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            id_q    <= '0;
            jump_q  <= VEC_BASE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= irq_in;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            jump_q  <= jump_d;
            req_q   <= (state_d == REQ);
            busy_q  <= (state_d == SERVICE);
        end
    end

    assign ir_req    = req_q;
    assign busy      = busy_q;
    assign ir_id     = id_q;
    assign jump_addr = jump_q;

    // Combinational register read
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            A_MASK:   cfg_rdata = 32'(mask_q);
            A_PEND:   cfg_rdata = 32'(pend_q);
            A_MODE:   cfg_rdata = 32'(mode_q);
            A_STATUS: cfg_rdata = 32'({busy_q, id_q});
            default:  cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl (default parameters); level-mode scenario runs only with IRQ_LEVEL_MODE_EN.
module tb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        cfg_wen;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        ir_req;
    logic [2:0]  ir_id;
    logic [31:0] jump_addr;
    logic        ir_ack;
    logic        eret;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    interrupt_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .cfg_wen   (cfg_wen),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ir_req    (ir_req),
        .ir_id     (ir_id),
        .jump_addr (jump_addr),
        .ir_ack    (ir_ack),
        .eret      (eret),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wen = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; irq_in = '0; cfg_wen = 0; cfg_addr = 0; cfg_wdata = 0; ir_ack = 0; eret = 0;
        tick(); tick();
        checks++;
        if (ir_req !== 1'b0 || busy !== 1'b0 || jump_addr !== 32'h100 || ir_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b busy=%b jump=%h id=%0d, want 0 0 00000100 0", ir_req, busy, jump_addr, ir_id);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h want 0", a, d);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d;
        wr(2'd0, 32'h04);
        irq_in = 8'h04; tick(); irq_in = 8'h00;
        rd(2'd1, d);
        checks++;
        if (ir_req !== 1'b0 || d !== 32'h04) begin
            failures++;
            $display("FAIL basic_pend: req=%b pend=%h want 0 04", ir_req, d);
        end
        tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd2 || jump_addr !== 32'h120) begin
            failures++;
            $display("FAIL basic_req: req=%b id=%0d jump=%h want 1 2 00000120", ir_req, ir_id, jump_addr);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        rd(2'd1, d);
        checks++;
        if (busy !== 1'b1 || ir_req !== 1'b0 || d !== 32'h0) begin
            failures++;
            $display("FAIL basic_ack: busy=%b req=%b pend=%h want 1 0 0", busy, ir_req, d);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0A) begin
            failures++;
            $display("FAIL basic_status: got %h want 0000000a", d);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        checks++;
        if (busy !== 1'b0 || ir_req !== 1'b0 || ir_id !== 3'd2) begin
            failures++;
            $display("FAIL basic_eret: busy=%b req=%b id=%0d want 0 0 2", busy, ir_req, ir_id);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        wr(2'd0, 32'hFF);
        irq_in = 8'h22; tick(); irq_in = 8'h00; tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd1 || jump_addr !== 32'h110) begin
            failures++;
            $display("FAIL prio_first: req=%b id=%0d jump=%h want 1 1 00000110", ir_req, ir_id, jump_addr);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        rd(2'd1, d);
        checks++;
        if (d !== 32'h20) begin
            failures++;
            $display("FAIL prio_pend: got %h want 20", d);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        checks++;
        if (ir_req !== 1'b0) begin
            failures++;
            $display("FAIL prio_gap: req=%b want 0", ir_req);
        end
        tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd5 || jump_addr !== 32'h150) begin
            failures++;
            $display("FAIL prio_second: req=%b id=%0d jump=%h want 1 5 00000150", ir_req, ir_id, jump_addr);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic test_service_block();
        logic [31:0] d;
        irq_in = 8'h10; tick(); irq_in = 8'h00; tick();
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        irq_in = 8'h01; tick(); irq_in = 8'h00; tick(); tick();
        rd(2'd1, d);
        checks++;
        if (ir_req !== 1'b0 || busy !== 1'b1 || ir_id !== 3'd4 || d !== 32'h01) begin
            failures++;
            $display("FAIL svc_block: req=%b busy=%b id=%0d pend=%h want 0 1 4 01", ir_req, busy, ir_id, d);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd0 || jump_addr !== 32'h100) begin
            failures++;
            $display("FAIL svc_resume: req=%b id=%0d jump=%h want 1 0 00000100", ir_req, ir_id, jump_addr);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic test_masked_w1c();
        logic [31:0] d;
        wr(2'd0, 32'h00);
        irq_in = 8'h08; tick(); irq_in = 8'h00; tick();
        rd(2'd1, d);
        checks++;
        if (ir_req !== 1'b0 || d !== 32'h08) begin
            failures++;
            $display("FAIL mask_pend: req=%b pend=%h want 0 08", ir_req, d);
        end
        irq_in = 8'h08;
        wr(2'd1, 32'h08);
        irq_in = 8'h00;
        rd(2'd1, d);
        checks++;
        if (d !== 32'h08) begin
            failures++;
            $display("FAIL w1c_collide: pend=%h want 08", d);
        end
        wr(2'd1, 32'h08);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h00) begin
            failures++;
            $display("FAIL w1c_clear: pend=%h want 00", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        wr(2'd0, 32'hFF);
        irq_in = 8'h40; tick(); irq_in = 8'h00; tick();
        wr(2'd0, 32'h00);
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd6 || jump_addr !== 32'h160) begin
            failures++;
            $display("FAIL req_hold: req=%b id=%0d jump=%h want 1 6 00000160", ir_req, ir_id, jump_addr);
        end
        wr(2'd0, 32'hFF);
        ir_ack = 1'b1; irq_in = 8'h40; tick(); ir_ack = 1'b0; irq_in = 8'h00;
        rd(2'd1, d);
        checks++;
        if (busy !== 1'b1 || d !== 32'h40) begin
            failures++;
            $display("FAIL ack_collide: busy=%b pend=%h want 1 40", busy, d);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd6) begin
            failures++;
            $display("FAIL rerequest: req=%b id=%0d want 1 6", ir_req, ir_id);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        checks++;
        if (ir_req !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL eret_in_req: req=%b busy=%b want 1 0", ir_req, busy);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        checks++;
        if (ir_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ack_in_idle: req=%b busy=%b want 0 0", ir_req, busy);
        end
`ifndef IRQ_LEVEL_MODE_EN
        wr(2'd2, 32'hFF);
        rd(2'd2, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL mode_disabled: got %h want 0", d);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        irq_in = 8'h02; tick(); irq_in = 8'h00; tick();
        checks++;
        if (ir_req !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: req=%b want 1", ir_req);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ir_req !== 1'b0 || busy !== 1'b0 || jump_addr !== 32'h100) begin
            failures++;
            $display("FAIL abort_async: req=%b busy=%b jump=%h want 0 0 00000100", ir_req, busy, jump_addr);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL abort_reg%0d: got %h want 0", a, d);
            end
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

`ifdef IRQ_LEVEL_MODE_EN
    task automatic test_level_mode();
        logic [31:0] d;
        wr(2'd0, 32'h01);
        wr(2'd2, 32'h01);
        irq_in = 8'h01; tick(); tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd0) begin
            failures++;
            $display("FAIL level_req1: req=%b id=%0d want 1 0", ir_req, ir_id);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        rd(2'd1, d);
        checks++;
        if (d !== 32'h01) begin
            failures++;
            $display("FAIL level_pend_ack: got %h want 01", d);
        end
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++;
        if (ir_req !== 1'b1 || ir_id !== 3'd0) begin
            failures++;
            $display("FAIL level_req2: req=%b id=%0d want 1 0", ir_req, ir_id);
        end
        ir_ack = 1'b1; tick(); ir_ack = 1'b0;
        irq_in = 8'h00; tick();
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++;
        if (ir_req !== 1'b0) begin
            failures++;
            $display("FAIL level_stop: req=%b want 0", ir_req);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_service_block();
        test_masked_w1c();
        test_back_to_back();
        test_reset_abort();
`ifdef IRQ_LEVEL_MODE_EN
        test_level_mode();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
